// File: rtl/hex_result_formatter_if.sv
// Word-in / character-out handshake bundle for hex_result_formatter.
// The slave modport is the formatter's view; master is the driver/sink side.
interface hex_result_formatter_if #(
    parameter int W = 128
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_char;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_char, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_char, out_last
    );
endinterface

// File: rtl/hex_result_formatter.sv
// Streams one captured W-bit word as lowercase ASCII hex, MSB nibble first,
// one character per cycle, with an optional trailing newline.
module hex_result_formatter #(
    parameter int W            = 128,
    parameter int EMIT_NEWLINE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    hex_result_formatter_if.slave  bus,
    output logic                   busy
);
    localparam int NIBBLES = W / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_NL
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_sr;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     w_nib;
    logic [7:0]     w_char;
    logic           w_last;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sr    <= bus.in_data;
                        r_cnt   <= CW'(NIBBLES - 1);
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_sr <= r_sr << 4;
                        if (r_cnt == '0) begin
                            r_state <= (EMIT_NEWLINE != 0) ? S_NL : S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_NL: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_nib = r_sr[W-1 -: 4];

    // Outputs decode registered state only, so out_ready/in_* never reach them.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can infer a latch.
        w_char = 8'h00;
        w_last = 1'b0;
        case (r_state)
            S_EMIT: begin
                w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                         : (8'h57 + {4'h0, w_nib});
                w_last = (EMIT_NEWLINE == 0) && (r_cnt == '0);
            end
            S_NL: begin
                w_char = 8'h0A;
                w_last = 1'b1;
            end
            default: begin
                w_char = 8'h00;
                w_last = 1'b0;
            end
        endcase
    end

    assign bus.out_char  = w_char;
    assign bus.out_last  = w_last;
    assign bus.out_valid = (r_state != S_IDLE);
    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_hex_result_formatter.sv
// Scoreboard bench: stimulus pushes expected characters, per-DUT monitors
// pop and compare on every output handshake.
module tb_hex_result_formatter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic s_busy;

    always #5 clk = ~clk;

    hex_result_formatter_if #(.W(128)) bif ();
    hex_result_formatter_if #(.W(8))   sif ();

    hex_result_formatter #(.W(128), .EMIT_NEWLINE(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bif.slave),
        .busy (busy)
    );

    hex_result_formatter #(.W(8), .EMIT_NEWLINE(0)) s_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (sif.slave),
        .busy (s_busy)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic       last;
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    bit   bp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic void push_str(input string s, input bit nl);
        for (int i = 0; i < s.len(); i++) q.push_back('{ch: s[i], last: 1'b0});
        if (nl) q.push_back('{ch: 8'h0A, last: 1'b1});
    endfunction

    function automatic void push_rep(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) q.push_back('{ch: c, last: 1'b0});
    endfunction

    function automatic void push_word(input logic [127:0] d);
        logic [3:0] nib;
        for (int i = 31; i >= 0; i--) begin
            nib = d[4*i +: 4];
            q.push_back('{ch: (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h61 + 8'(nib - 4'd10), last: 1'b0});
        end
        q.push_back('{ch: 8'h0A, last: 1'b1});
    endfunction

    // Monitor for the W=128 instance, including stall-stability checks.
    initial begin : mon_big
        bit         pend = 1'b0;
        logic [8:0] prev = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("stall_valid", bif.out_valid, 1'b1);
                check("stall_char", {bif.out_char, bif.out_last}, prev);
            end
            if (bif.out_valid && bif.out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    fail_now("spurious_char");
                end else begin
                    e = q.pop_front();
                    check("char", bif.out_char, e.ch);
                    check("last", bif.out_last, e.last);
                end
            end
            pend = bif.out_valid && !bif.out_ready;
            prev = {bif.out_char, bif.out_last};
        end
    end

    initial begin : mon_small
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sif.out_valid && sif.out_ready) begin
                if (sq.size() == 0) begin
                    fail_now("small_spurious_char");
                end else begin
                    e = sq.pop_front();
                    check("small_char", sif.out_char, e.ch);
                    check("small_last", sif.out_last, e.last);
                end
            end
        end
    end

    initial begin : bp_drv
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) bif.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [127:0] d);
        int t = 0;
        while (!bif.in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) fail_now("send_timeout");
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) fail_now("drain_timeout");
    endtask

    initial begin : stim
        int          cyc;
        int          base;
        int          t;
        logic [127:0] d;

        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", bif.in_ready, 1'b0);
        check("rst_out_valid", bif.out_valid, 1'b0);
        check("rst_out_char", bif.out_char, 8'h00);
        check("rst_out_last", bif.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", bif.in_ready, 1'b1);

        // Directed pattern: latency, full stream, word length.
        push_str("0123456789abcdeffedcba9876543210", 1'b1);
        send(128'h0123456789abcdeffedcba9876543210);
        @(negedge clk);
        check("first_digit_latency", bif.out_valid, 1'b1);
        cyc = 1;
        while (!bif.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("word_cycles_to_idle", cyc, 34);
        wait_done();

        // All zeros and all ones, back to back.
        push_rep(8'h30, 32);
        q.push_back('{ch: 8'h0A, last: 1'b1});
        send('0);
        push_rep(8'h66, 32);
        q.push_back('{ch: 8'h0A, last: 1'b1});
        send('1);
        wait_done();

        // Random backpressure over 20 words.
        bp_en = 1'b1;
        for (int w = 0; w < 20; w++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            push_word(d);
            send(d);
        end
        wait_done();
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b1;

        // in_valid held with changing data during a word: no extra capture.
        push_str("deadbeef00112233445566778899aabb", 1'b1);
        send(128'hdeadbeef00112233445566778899aabb);
        check("ignored_in_ready", bif.in_ready, 1'b0);
        t = 0;
        while (busy && t < 100) begin
            bif.in_data  = {$urandom, $urandom, $urandom, $urandom};
            bif.in_valid = !bif.out_last;
            @(posedge clk);
            #1;
            t++;
        end
        bif.in_valid = 1'b0;
        wait_done();
        check("no_extra_capture", busy, 1'b0);

        // Reset after the 5th digit.
        d = 128'h13579bdf02468ace13579bdf02468ace;
        push_word(d);
        base = n_out;
        send(d);
        t = 0;
        while (n_out < base + 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bif.out_valid, 1'b0);
        check("midrst_out_char", bif.out_char, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", bif.in_ready, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_rep(8'h30, 30);
        push_str("a5", 1'b1);
        send(128'hA5);
        wait_done();

        // W=8, no newline: "3" then "c" (last), three cycles per word.
        sq.push_back('{ch: 8'h33, last: 1'b0});
        sq.push_back('{ch: 8'h63, last: 1'b1});
        sif.in_valid = 1'b1;
        sif.in_data  = 8'h3C;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        @(negedge clk);
        check("small_busy_c1", s_busy, 1'b1);
        @(negedge clk);
        check("small_busy_c2", s_busy, 1'b1);
        @(negedge clk);
        check("small_in_ready_c3", sif.in_ready, 1'b1);

        repeat (2) @(negedge clk);
        check("big_queue_drained", q.size(), 0);
        check("small_queue_drained", sq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
